uart_mmio: RTL and testbench



---
 rtl/uart_mmio_pkg.sv | 31 +++
 rtl/uart_mmio_fifo.sv | 64 ++++++
 rtl/uart_mmio.sv | 185 ++++++++++++++++++
 tb/tb_uart_mmio.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_mmio_pkg
//  Description : Shared definitions for the memory-mapped UART transmitter:
//                register offsets, STATUS bit positions, FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_mmio_pkg;

    // Register window offsets (byte address within the 8-byte window)
    localparam logic [2:0] TXDATA_OFFSET = 3'd0;
    localparam logic [2:0] STATUS_OFFSET = 3'd4;

    // STATUS register bit positions
    localparam int STATUS_FULL_BIT   = 0;
    localparam int STATUS_EMPTY_BIT  = 1;
    localparam int STATUS_ACTIVE_BIT = 2;
    localparam int STATUS_OVF_BIT    = 3;
    localparam int STATUS_COUNT_LSB  = 4;
    localparam int STATUS_COUNT_MSB  = 8;

    // Transmit FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_mmio_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sync
//  Description : Single-clock show-ahead FIFO. Read data always presents the
//                oldest entry; push is ignored when full, pop when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : uart_mmio
//  Description : Memory-mapped 8N1 UART transmitter with TX FIFO, sticky
//                overflow flag and combinational STATUS read-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 104,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        selected,
    output logic [31:0] read_data,
    output logic        tx,
    output logic        busy
);
    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TIMER_W-1:0] c_timer_last = TIMER_W'(CLKS_PER_BIT - 1);

    logic               w_is_status;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_ovf_clear;
    logic               w_full;
    logic               w_empty;
    logic [COUNT_W-1:0] w_count;
    logic [COUNT_W-1:0] w_count_next;
    logic [7:0]         w_fifo_data;
    logic [31:0]        w_status;
    logic               w_bit_done;
    logic               w_unused;

    tx_state_t          r_state,   w_state_next;
    logic [TIMER_W-1:0] r_timer,   w_timer_next;
    logic [2:0]         r_bit_idx, w_bit_idx_next;
    logic [7:0]         r_shift,   w_shift_next;
    logic               r_tx,      w_tx_next;
    logic               r_overflow;
    logic               r_busy;

    // Address decode: bit 2 selects STATUS, bits [1:0] are don't-care
    assign selected    = (address[31:3] == BASE_ADDRESS[31:3]);
    assign w_is_status = (address[2] == STATUS_OFFSET[2]);
    assign w_push_req  = mem_write && selected && !w_is_status;
    assign w_push      = w_push_req && !w_full;
    assign w_ovf_clear = mem_write && selected && w_is_status && write_data[STATUS_OVF_BIT];
    assign w_unused    = ^{write_data[31:8], address[1:0]};

    assign tx   = r_tx;
    assign busy = r_busy;

    fifo_sync #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .wdata (write_data[7:0]),
        .pop   (w_pop),
        .rdata (w_fifo_data),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // STATUS word and read mux; TXDATA reads as zero
    always_comb begin
        w_status = '0;
        w_status[STATUS_FULL_BIT]   = w_full;
        w_status[STATUS_EMPTY_BIT]  = w_empty;
        w_status[STATUS_ACTIVE_BIT] = (r_state != ST_IDLE);
        w_status[STATUS_OVF_BIT]    = r_overflow;
        w_status[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = 5'(w_count);
        read_data = (selected && w_is_status) ? w_status : '0;
    end

    // Transmit FSM next-state: a frame starts the same edge the FIFO pops
    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = r_timer;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_tx_next      = r_tx;
        w_pop          = 1'b0;
        w_bit_done     = (r_timer == c_timer_last);
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_data;
                    w_tx_next    = 1'b0;
                    w_timer_next = '0;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_timer_next   = '0;
                    w_bit_idx_next = '0;
                    w_tx_next      = r_shift[0];
                    w_state_next   = ST_DATA;
                end else begin
                    w_timer_next = r_timer + TIMER_W'(1);
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    w_timer_next = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_tx_next    = 1'b1;
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                        w_shift_next   = {1'b0, r_shift[7:1]};
                        w_tx_next      = r_shift[1];
                    end
                end else begin
                    w_timer_next = r_timer + TIMER_W'(1);
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    w_timer_next = '0;
                    if (!w_empty) begin
                        // Chain straight into the next frame, no idle gap
                        w_pop        = 1'b1;
                        w_shift_next = w_fifo_data;
                        w_tx_next    = 1'b0;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_timer_next = r_timer + TIMER_W'(1);
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_count_next = w_count + COUNT_W'(w_push) - COUNT_W'(w_pop);

    // FSM, shifter, line and busy registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
            r_busy    <= (w_state_next != ST_IDLE) || (w_count_next != '0);
        end
    end

    // Sticky overflow: a dropped push outranks a software clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_push_req && w_full) begin
            r_overflow <= 1'b1;
        end else if (w_ovf_clear) begin
            r_overflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_mmio
//  Description : Self-checking bench for uart_mmio. A line receiver decodes
//                the tx pin independently and scores frames against the
//                queue of bytes the bench expects to be sent.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mmio;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_write = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic        selected;
    logic [31:0] read_data;
    logic        tx;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    bit         mon_busy = 1'b0;
    int         mon_cnt  = 0;
    logic [7:0] mon_byte = 8'h0;

    uart_mmio #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .BASE_ADDRESS (32'h0000_1000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .selected   (selected),
        .read_data  (read_data),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Line receiver: sample mid-bit, score each completed frame
    always @(negedge clock) begin
        if (!reset) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (tx === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % CPB == CPB / 2) begin
                if (mon_cnt / CPB == 0) begin
                    n_tests++;
                    if (tx !== 1'b0) begin
                        n_fail++;
                        $display("FAIL start_bit: tx=%b required 0", tx);
                    end
                end else if (mon_cnt / CPB <= 8) begin
                    mon_byte[mon_cnt / CPB - 1] = tx;
                end else begin
                    mon_busy = 1'b0;
                    n_tests++;
                    if (tx !== 1'b1) begin
                        n_fail++;
                        $display("FAIL stop_bit: tx=%b required 1", tx);
                    end
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL frame_unexpected: got 0x%02h required none", mon_byte);
                    end else if (mon_byte !== exp_q[0]) begin
                        n_fail++;
                        $display("FAIL frame_data: got 0x%02h required 0x%02h", mon_byte, exp_q[0]);
                        void'(exp_q.pop_front());
                    end else begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // One bus store; returns at the negedge following the write edge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        address    = a;
        write_data = d;
        mem_write  = 1'b1;
        @(negedge clock);
        mem_write  = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1 address = 32'h1004;
        #1;
        n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b required 1", tx); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_tests++; if (selected !== 1'b1) begin n_fail++; $display("FAIL reset_selected: got %b required 1", selected); end
        n_tests++; if (read_data !== 32'h2) begin n_fail++; $display("FAIL reset_status: got 0x%08h required 0x2", read_data); end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_tests++; if (read_data !== 32'h2 || tx !== 1'b1) begin n_fail++; $display("FAIL post_reset: status=0x%08h tx=%b required 0x2/1", read_data, tx); end
    endtask

    task automatic test_single_frame();
        logic [7:0] b = 8'h55;
        logic       expb;
        int         errs = 0;
        exp_q.push_back(b);
        bus_write(32'h1000, {24'hABCDEF, b});
        address = 32'h1004;
        #1;
        n_tests++; if (read_data !== 32'h10 || tx !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL push_status: status=0x%08h tx=%b busy=%b required 0x10/1/1", read_data, tx, busy); end
        @(negedge clock);
        n_tests++; if (read_data !== 32'h6 || tx !== 1'b0) begin n_fail++; $display("FAIL pop_status: status=0x%08h tx=%b required 0x6/0", read_data, tx); end
        for (int i = 0; i < 10 * CPB; i++) begin
            if (i > 0) @(negedge clock);
            expb = (i / CPB == 0) ? 1'b0 : (i / CPB == 9) ? 1'b1 : b[i / CPB - 1];
            if (tx !== expb) errs++;
            if (i == 10 * CPB - 1) begin
                n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_last_stop: got %b required 1", busy); end
            end
        end
        n_tests++; if (errs != 0) begin n_fail++; $display("FAIL frame_shape: %0d bad cycles required 0", errs); end
        @(negedge clock);
        n_tests++; if (busy !== 1'b0 || tx !== 1'b1 || read_data !== 32'h2) begin n_fail++; $display("FAIL frame_end: busy=%b tx=%b status=0x%08h required 0/1/0x2", busy, tx, read_data); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_rx: %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int t = 0;
        start_q.delete();
        for (int v = 1; v <= 6; v++) begin
            if (v <= 5) exp_q.push_back(8'(v));
            address    = 32'h1000;
            write_data = 32'(v);
            mem_write  = 1'b1;
            @(negedge clock);
        end
        mem_write = 1'b0;
        address   = 32'h1004;
        #1;
        n_tests++; if (read_data !== 32'h4D) begin n_fail++; $display("FAIL overflow_set: status=0x%08h required 0x4d", read_data); end
        bus_write(32'h1004, 32'hFFFF_FFF7);
        #1;
        n_tests++; if (read_data !== 32'h4D) begin n_fail++; $display("FAIL overflow_keep: status=0x%08h required 0x4d", read_data); end
        bus_write(32'h1004, 32'h8);
        #1;
        n_tests++; if (read_data !== 32'h45) begin n_fail++; $display("FAIL overflow_clear: status=0x%08h required 0x45", read_data); end
        while (busy !== 1'b0 && t < 400) begin @(negedge clock); t++; end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout: busy=%b required 0", busy); end
        n_tests++; if (exp_q.size() != 0 || start_q.size() != 5) begin n_fail++; $display("FAIL b2b_frames: pending=%0d starts=%0d required 0/5", exp_q.size(), start_q.size()); end
        for (int i = 1; i < start_q.size(); i++) begin
            n_tests++; if (start_q[i] - start_q[i-1] != 10 * CPB) begin n_fail++; $display("FAIL b2b_gap: got %0d required %0d", start_q[i] - start_q[i-1], 10 * CPB); end
        end
    endtask

    task automatic test_status_read();
        int t = 0;
        for (int v = 0; v < 3; v++) begin
            exp_q.push_back(8'h11 * 8'(v + 1));
            bus_write(32'h1000, 32'h11 * 32'(v + 1));
        end
        address = 32'h1004;
        #1;
        n_tests++; if (read_data !== 32'h24) begin n_fail++; $display("FAIL status_two: status=0x%08h required 0x24", read_data); end
        while (busy !== 1'b0 && t < 300) begin @(negedge clock); t++; end
        n_tests++; if (busy !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL status_drain: busy=%b pending=%0d required 0/0", busy, exp_q.size()); end
    endtask

    task automatic test_reset_midframe();
        int errs = 0;
        bus_write(32'h1000, 32'hF0);
        bus_write(32'h1000, 32'hAA);
        bus_write(32'h1000, 32'hBB);
        repeat (16) @(negedge clock);
        n_tests++; if (tx !== 1'b0) begin n_fail++; $display("FAIL mid_bit3: tx=%b required 0", tx); end
        #2 reset = 1'b0;
        #1;
        n_tests++; if (tx !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL async_reset: tx=%b busy=%b required 1/0", tx, busy); end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        start_q.delete();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (tx !== 1'b1) errs++;
        end
        address = 32'h1004;
        #1;
        n_tests++; if (errs != 0 || start_q.size() != 0) begin n_fail++; $display("FAIL reset_quiet: low=%0d starts=%0d required 0/0", errs, start_q.size()); end
        n_tests++; if (read_data !== 32'h2 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_flush: status=0x%08h busy=%b required 0x2/0", read_data, busy); end
    endtask

    task automatic test_unselected();
        address = 32'h2000;
        #1;
        n_tests++; if (selected !== 1'b0 || read_data !== 32'h0) begin n_fail++; $display("FAIL unsel_read: sel=%b data=0x%08h required 0/0", selected, read_data); end
        address = 32'h2004;
        #1;
        n_tests++; if (selected !== 1'b0 || read_data !== 32'h0) begin n_fail++; $display("FAIL unsel_status: sel=%b data=0x%08h required 0/0", selected, read_data); end
        address = 32'h1000;
        #1;
        n_tests++; if (selected !== 1'b1 || read_data !== 32'h0) begin n_fail++; $display("FAIL txdata_read: sel=%b data=0x%08h required 1/0", selected, read_data); end
        @(negedge clock);
        bus_write(32'h2000, 32'h77);
        address = 32'h1004;
        #1;
        n_tests++; if (read_data !== 32'h2 || busy !== 1'b0) begin n_fail++; $display("FAIL unsel_store: status=0x%08h busy=%b required 0x2/0", read_data, busy); end
    endtask

    task automatic test_random();
        int n;
        int t;
        logic [7:0] b;
        for (int burst = 0; burst < 6; burst++) begin
            n = $urandom_range(1, DEPTH);
            start_q.delete();
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 3)) @(negedge clock);
                b = 8'($urandom);
                exp_q.push_back(b);
                bus_write(32'h1000 | 32'($urandom_range(0, 3)), {24'($urandom), b});
            end
            t = 0;
            while (busy !== 1'b0 && t < 10 * CPB * DEPTH + 60) begin @(negedge clock); t++; end
            address = 32'h1004;
            #1;
            n_tests++; if (busy !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain: busy=%b pending=%0d required 0/0", busy, exp_q.size()); end
            n_tests++; if (start_q.size() != n || read_data !== 32'h2) begin n_fail++; $display("FAIL rand_frames: starts=%0d status=0x%08h required %0d/0x2", start_q.size(), read_data, n); end
            for (int i = 1; i < start_q.size(); i++) begin
                n_tests++; if (start_q[i] - start_q[i-1] != 10 * CPB) begin n_fail++; $display("FAIL rand_gap: got %0d required %0d", start_q[i] - start_q[i-1], 10 * CPB); end
            end
            @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_status_read();
        test_reset_midframe();
        test_unselected();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
